// File: rtl/mod_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mod_counter
//  Purpose  : Up/down modulo counter with terminal value MAX, three boundary
//             behaviours (wrap, saturate, one-shot), a registered terminal-
//             count pulse, a sticky boundary flag and a one-shot run flag.
//             Optional feature macro: MOD_COUNTER_PRESC_EN adds a PRESC_W-bit
//             prescaler and the presc port; without it every enabled cycle
//             is a tick.
//  Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}},
   parameter int unsigned      PRESC_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clr,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   input  logic               en,
   input  logic               dir,
   input  logic [1:0]         mode,
   input  logic               ovf_clr,
`ifdef MOD_COUNTER_PRESC_EN
   input  logic [PRESC_W-1:0] presc,
`endif
   output logic [WIDTH-1:0]   count,
   output logic               tc,
   output logic               ovf,
   output logic               running
);

   // Boundary behaviour encodings; 2'b11 falls through to wrap.
   localparam logic [1:0]       C_MODE_WRAP = 2'b00;
   localparam logic [1:0]       C_MODE_SAT  = 2'b01;
   localparam logic [1:0]       C_MODE_ONE  = 2'b10;
   localparam logic [WIDTH-1:0] C_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] C_ZERO      = {WIDTH{1'b0}};

   // Architectural state
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             running_q, running_d;

   // Decode helpers
   logic             w_tick;
   logic             w_step;
   logic             w_at_bound;
   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH-1:0] w_count_inc;
   logic [WIDTH-1:0] w_count_dec;

`ifdef MOD_COUNTER_PRESC_EN
   localparam logic [PRESC_W-1:0] C_PONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
   localparam logic [PRESC_W-1:0] C_PZERO = {PRESC_W{1'b0}};

   logic [PRESC_W-1:0] presc_q, presc_d;

   // A tick fires once the prescaler has reached the programmed divisor-1;
   // comparing with >= lets a smaller new presc value take effect at once.
   assign w_tick = (presc_q >= presc);

   // Prescaler next state: restart on clr/load, advance only while counting.
   always_comb begin
      presc_d = presc_q;
      if (clr || load) begin
         presc_d = C_PZERO;
      end else if (en && running_q) begin
         presc_d = w_tick ? C_PZERO : (presc_q + C_PONE);
      end
   end

   // Prescaler register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= C_PZERO;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   // No prescaler: every enabled cycle is a tick.
   assign w_tick = 1'b1;
`endif

   assign w_load_clamped = (load_val > MAX) ? MAX : load_val;
   assign w_count_inc    = count_q + C_ONE;
   assign w_count_dec    = count_q - C_ONE;
   assign w_at_bound     = dir ? (count_q == MAX) : (count_q == C_ZERO);
   assign w_step         = en && w_tick && running_q && !clr && !load;

   // Counter next state with priority clr > load > step.
   always_comb begin
      count_d   = count_q;
      tc_d      = 1'b0;
      running_d = running_q;
      if (clr) begin
         count_d   = C_ZERO;
         running_d = 1'b1;
      end else if (load) begin
         count_d   = w_load_clamped;
         running_d = 1'b1;
      end else if (w_step) begin
         if (!w_at_bound) begin
            count_d = dir ? w_count_inc : w_count_dec;
         end else begin
            case (mode)
               C_MODE_SAT: begin
                  count_d = count_q;
               end
               C_MODE_ONE: begin
                  count_d   = count_q;
                  tc_d      = 1'b1;
                  running_d = 1'b0;
               end
               default: begin
                  // C_MODE_WRAP and the unused encoding both wrap.
                  count_d = dir ? C_ZERO : MAX;
                  tc_d    = 1'b1;
               end
            endcase
         end
      end
   end

   // Sticky boundary flag: a boundary step wins over a same-cycle clear.
   always_comb begin
      ovf_d = ovf_q;
      if (w_step && w_at_bound) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   // Counter, pulse and flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q   <= C_ZERO;
         tc_q      <= 1'b0;
         ovf_q     <= 1'b0;
         running_q <= 1'b1;
      end else begin
         count_q   <= count_d;
         tc_q      <= tc_d;
         ovf_q     <= ovf_d;
         running_q <= running_d;
      end
   end

   assign count   = count_q;
   assign tc      = tc_q;
   assign ovf     = ovf_q;
   assign running = running_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mod_counter
//  Purpose  : Self-checking bench for mod_counter (WIDTH=8, MAX=9): vector
//             table, hand sequences for reset/prescaler corners, and a
//             randomized run against an integer reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mod_counter;

   localparam int MAXV = 9;

   logic       clk;
   logic       reset_n;
   logic       clr;
   logic       load;
   logic [7:0] load_val;
   logic       en;
   logic       dir;
   logic [1:0] mode;
   logic       ovf_clr;
   logic [3:0] presc;
   logic [7:0] count;
   logic       tc;
   logic       ovf;
   logic       running;

   int n_checks = 0;
   int n_errs   = 0;

   // Reference model state (plain integers)
   int m_cnt;
   int m_pre;
   bit m_tc;
   bit m_ovf;
   bit m_run;

   mod_counter #(
      .WIDTH   (8),
      .MAX     (8'd9),
      .PRESC_W (4)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .en       (en),
      .dir      (dir),
      .mode     (mode),
      .ovf_clr  (ovf_clr),
`ifdef MOD_COUNTER_PRESC_EN
      .presc    (presc),
`endif
      .count    (count),
      .tc       (tc),
      .ovf      (ovf),
      .running  (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       clr;
      logic       load;
      logic [7:0] lv;
      logic       en;
      logic       dir;
      logic [1:0] mode;
      logic       oc;
      int         ec;
      logic       etc;
      logic       eovf;
      logic       erun;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic c, input logic l, input logic [7:0] lv,
                      input logic e, input logic d, input logic [1:0] md,
                      input logic oc, input int ec, input logic etc,
                      input logic eovf, input logic erun);
      vec_t v;
      v.clr = c; v.load = l; v.lv = lv; v.en = e; v.dir = d; v.mode = md;
      v.oc = oc; v.ec = ec; v.etc = etc; v.eovf = eovf; v.erun = erun;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int ec, input int etc,
                          input int eovf, input int erun);
      chk({tag, ".count"},   int'(count),   ec);
      chk({tag, ".tc"},      int'(tc),      etc);
      chk({tag, ".ovf"},     int'(ovf),     eovf);
      chk({tag, ".running"}, int'(running), erun);
   endtask

   task automatic model_reset();
      m_cnt = 0; m_pre = 0; m_tc = 0; m_ovf = 0; m_run = 1;
   endtask

   // Behavioural rules: compute the would-be next count in plain integers
   // and treat leaving the range 0..MAX as the boundary event.
   task automatic model_edge();
      int tgt;
      bit tick;
      bit bnd;
      bnd  = 0;
      tick = 1;
`ifdef MOD_COUNTER_PRESC_EN
      tick = (m_pre >= int'(presc));
`endif
      m_tc = 0;
      if (clr) begin
         m_cnt = 0; m_run = 1; m_pre = 0;
      end else if (load) begin
         m_cnt = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
         m_run = 1; m_pre = 0;
      end else begin
         if (en && m_run) m_pre = tick ? 0 : m_pre + 1;
         if (en && tick && m_run) begin
            tgt = dir ? m_cnt + 1 : m_cnt - 1;
            bnd = (tgt < 0) || (tgt > MAXV);
            if (!bnd) begin
               m_cnt = tgt;
            end else if (mode == 2'd1) begin
               m_cnt = m_cnt;
            end else if (mode == 2'd2) begin
               m_tc = 1; m_run = 0;
            end else begin
               m_cnt = (tgt + MAXV + 1) % (MAXV + 1);
               m_tc  = 1;
            end
         end
      end
      if (bnd) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
   endtask

   task automatic step_edge();
      @(posedge clk);
      if (reset_n) model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      clr = 0; load = 0; load_val = 0; en = 0; ovf_clr = 0;
   endtask

   initial begin
      reset_n = 0; clr = 0; load = 0; load_val = 0; en = 0;
      dir = 1; mode = 2'd0; ovf_clr = 0; presc = 4'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 0, 0, 0, 1);
      #2 reset_n = 1;

      // ---------------- vector table ----------------
      for (int k = 1; k <= 11; k++)
         add(0, 0, 8'd0, 1, 1, 2'd0, 0, k % 10, k == 10, k >= 10, 1);
      add(0, 1, 8'd2, 0, 0, 2'd1, 0, 2, 0, 1, 1);   // load 2, saturate down
      add(0, 0, 8'd0, 0, 0, 2'd1, 1, 2, 0, 0, 1);   // ovf_clr alone
      add(0, 0, 8'd0, 1, 0, 2'd1, 0, 1, 0, 0, 1);
      add(0, 0, 8'd0, 1, 0, 2'd1, 0, 0, 0, 0, 1);
      add(0, 0, 8'd0, 1, 0, 2'd1, 0, 0, 0, 1, 1);   // saturate boundary
      add(0, 0, 8'd0, 1, 0, 2'd1, 0, 0, 0, 1, 1);
      add(0, 0, 8'd0, 0, 0, 2'd1, 1, 0, 0, 0, 1);   // ovf_clr alone
      add(0, 0, 8'd0, 1, 0, 2'd1, 1, 0, 0, 1, 1);   // boundary beats ovf_clr
      add(0, 0, 8'd0, 0, 0, 2'd1, 1, 0, 0, 0, 1);
      add(0, 1, 8'd7, 0, 1, 2'd2, 0, 7, 0, 0, 1);   // one-shot up from 7
      add(0, 0, 8'd0, 1, 1, 2'd2, 0, 8, 0, 0, 1);
      add(0, 0, 8'd0, 1, 1, 2'd2, 0, 9, 0, 0, 1);
      add(0, 0, 8'd0, 1, 1, 2'd2, 0, 9, 1, 1, 0);   // one-shot stop
      add(0, 0, 8'd0, 1, 1, 2'd2, 0, 9, 0, 1, 0);
      add(0, 0, 8'd0, 1, 0, 2'd2, 0, 9, 0, 1, 0);   // ignored while stopped
      add(0, 1, 8'd200, 0, 1, 2'd2, 0, 9, 0, 1, 1); // clamped load restarts
      add(0, 1, 8'd5, 0, 1, 2'd0, 0, 5, 0, 1, 1);
      add(1, 1, 8'd3, 1, 1, 2'd0, 0, 0, 0, 1, 1);   // clr beats load and en
      add(0, 0, 8'd0, 0, 0, 2'd3, 1, 0, 0, 0, 1);
      add(0, 0, 8'd0, 1, 0, 2'd3, 0, 9, 1, 1, 1);   // mode 3 wraps down
      add(0, 0, 8'd0, 1, 1, 2'd3, 0, 0, 1, 1, 1);   // and up
      add(0, 0, 8'd0, 0, 1, 2'd3, 0, 0, 0, 1, 1);   // hold, tc drops

      foreach (tbl[i]) begin
         clr = tbl[i].clr; load = tbl[i].load; load_val = tbl[i].lv;
         en = tbl[i].en; dir = tbl[i].dir; mode = tbl[i].mode;
         ovf_clr = tbl[i].oc;
         step_edge();
         chk_all($sformatf("vec%0d", i), tbl[i].ec, tbl[i].etc,
                 tbl[i].eovf, tbl[i].erun);
      end
      idle_inputs();

      // ---------------- async reset with count=6 ----------------
      load = 1; load_val = 8'd6; mode = 2'd0; dir = 1;
      step_edge();
      load = 0;
      chk_all("pre_rst", 6, 0, 1, 1);
      #2 reset_n = 0;
      model_reset();
      #1;
      chk_all("async_rst", 0, 0, 0, 1);
      reset_n = 1;

      // ---------------- reset aborts a tc pulse ----------------
      load = 1; load_val = 8'd9;
      step_edge();
      load = 0; en = 1;
      step_edge();
      chk_all("wrap_tc", 0, 1, 1, 1);
      reset_n = 0;
      model_reset();
      #1;
      chk_all("tc_abort", 0, 0, 0, 1);
      #1 reset_n = 1;
      step_edge();
      chk_all("first_step", 1, 0, 0, 1);
      idle_inputs();

`ifdef MOD_COUNTER_PRESC_EN
      // ---------------- prescaler divide-by-3 with en gaps ----------------
      presc = 4'd2; clr = 1;
      step_edge();
      clr = 0; en = 1; dir = 1; mode = 2'd0;
      step_edge(); chk("presc_e1", int'(count), 0);
      step_edge(); chk("presc_e2", int'(count), 0);
      step_edge(); chk("presc_e3", int'(count), 1);
      step_edge(); chk("presc_e4", int'(count), 1);
      en = 0;
      step_edge(); chk("presc_hold1", int'(count), 1);
      step_edge(); chk("presc_hold2", int'(count), 1);
      en = 1;
      step_edge(); chk("presc_e7", int'(count), 1);
      step_edge(); chk("presc_e8", int'(count), 2);
      idle_inputs();
`endif

      // ---------------- randomized run against the model ----------------
      chk_all("pre_random", m_cnt, int'(m_tc), int'(m_ovf), int'(m_run));
      for (int n = 0; n < 800; n++) begin
         clr      = ($urandom % 25) == 0;
         load     = ($urandom % 12) == 0;
         load_val = 8'($urandom_range(0, 255));
         en       = ($urandom % 4) != 0;
         if (($urandom % 8) == 0) dir = ~dir;
         if (($urandom % 10) == 0) mode = 2'($urandom_range(0, 3));
         ovf_clr  = ($urandom % 6) == 0;
         presc    = 4'($urandom_range(0, 3));
         step_edge();
         chk_all($sformatf("rnd%0d", n), m_cnt, int'(m_tc), int'(m_ovf),
                 int'(m_run));
         chk($sformatf("rnd%0d.le_max", n), int'(count <= 8'd9), 1);
         if (($urandom % 60) == 0) begin
            reset_n = 0;
            model_reset();
            #2;
            chk_all($sformatf("rnd%0d.rst", n), 0, 0, 0, 1);
            reset_n = 1;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits, SHALL be 2..32.
REQ-002 Parameter MAX, default 2**WIDTH-1, terminal value, SHALL be 1..2**WIDTH-1.
REQ-003 Parameter PRESC_W, default 4, prescaler width in bits, used only when MOD_COUNTER_PRESC_EN is defined.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 clr  in  1  synchronous clear to 0.
REQ-007 load  in  1  synchronous load of load_val.
REQ-008 load_val  in  WIDTH  load value.
REQ-009 en  in  1  count enable.
REQ-010 dir  in  1  direction: 1 up, 0 down.
REQ-011 mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-012 ovf_clr  in  1  clears the sticky ovf flag.
REQ-013 presc  in  PRESC_W  prescale divisor minus 1; present only with MOD_COUNTER_PRESC_EN.
REQ-014 count  out  WIDTH  current count, registered.
REQ-015 tc  out  1  registered one-cycle terminal-count pulse.
REQ-016 ovf  out  1  sticky boundary flag.
REQ-017 running  out  1  0 once one-shot has stopped, else 1.

Function
REQ-018 Priority SHALL be clr > load > step; a step occurs on a cycle where en=1 and tick=1, running=1 and neither clr nor load is asserted.
REQ-019 clr SHALL set count=0, running=1, tc=0 and clear the prescaler; ovf is unaffected.
REQ-020 load SHALL set count=min(load_val, MAX), running=1, tc=0 and clear the prescaler.
REQ-021 A non-boundary step SHALL change count by +1 (dir=1) or -1 (dir=0), with result visible on count the next cycle.
REQ-022 A boundary step is a step with count==MAX and dir=1, or count==0 and dir=0.
REQ-023 Wrap mode boundary step: count SHALL become 0 (up) or MAX (down); tc=1 for that one cycle; ovf set.
REQ-024 Saturate mode boundary step: count SHALL hold; tc stays 0; ovf set.
REQ-025 One-shot mode boundary step: count SHALL hold; tc=1 for one cycle; ovf set; running cleared; later steps are ignored until clr or load.
REQ-026 tc SHALL be 0 on every cycle except the one following a wrap or one-shot boundary step.
REQ-027 ovf SHALL be cleared by ovf_clr; a boundary step in the same cycle as ovf_clr SHALL leave ovf=1.
REQ-028 Changing mode or dir SHALL take effect on the next step, with no other side effect.
REQ-029 count SHALL never exceed MAX.

Reset
REQ-030 reset_n=0 SHALL immediately force count=0, tc=0, ovf=0, running=1 and prescaler=0, independent of clk.
REQ-031 Reset asserted mid-count SHALL abort the count with no tc pulse; after release, the first step occurs on the first rising edge with en=1 and tick=1.

Configuration
REQ-032 Macro MOD_COUNTER_PRESC_EN defined: a PRESC_W-bit prescaler SHALL advance on cycles with en=1 and running=1 and hold when en=0; tick=1 when prescaler>=presc, and the prescaler then returns to 0; presc=0 gives a step every enabled cycle; a new presc value takes effect at the next compare.
REQ-033 Macro MOD_COUNTER_PRESC_EN undefined: the presc port and prescaler logic SHALL be absent and tick SHALL be held at 1.

Verification
REQ-034 WIDTH=8, MAX=9, wrap, dir=1, en=1 for 12 cycles from reset -> count 0..9,0,1; tc=1 exactly one cycle after the count 9->0 step; ovf=1.
REQ-035 Saturate, dir=0, load_val=2, then en=1 for 5 cycles -> count 2,1,0,0,0; tc never 1; ovf=1; ovf_clr alone -> ovf=0.
REQ-036 One-shot, MAX=3, up from 0 -> count 0..3 then holds at 3, one tc pulse, running=0; load=1 with load_val=7 -> count=3 (clamped), running=1.
REQ-037 clr, load and en asserted together with count=5 -> count=0; a boundary step in the same cycle as ovf_clr -> ovf=1.
REQ-038 reset_n pulsed low between clk edges with count=6 -> count=0, tc=0 and ovf=0 before the next edge; with MOD_COUNTER_PRESC_EN and presc=2 -> one step every 3 enabled cycles, and the prescaler holds while en=0.
